// File: rtl/snake_sound_pkg.sv
// Shared types and note constants for the snake-game audio path.
// Event encoding doubles as priority: a larger value wins arbitration.
package snake_sound_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DIR  = 2'd1,
        GOOD = 2'd2,
        BAD  = 2'd3
    } evt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam logic [7:0] NOTE_C  = 8'd149;
    localparam logic [7:0] NOTE_DS = 8'd126;
    localparam logic [7:0] NOTE_E  = 8'd118;
    localparam logic [7:0] NOTE_G  = 8'd100;
    localparam logic [7:0] NOTE_A  = 8'd89;

    // Request vector is indexed [3:1] by event value.
    function automatic evt_t top_evt(input logic [3:1] req);
        if (req[3])      return BAD;
        else if (req[2]) return GOOD;
        else if (req[1]) return DIR;
        else             return NONE;
    endfunction

    function automatic logic [3:1] evt_mask(input evt_t e);
        case (e)
            DIR:     return 3'b001;
            GOOD:    return 3'b010;
            BAD:     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sound_event_sequencer_jingle_rom.sv
// Combinational jingle table: note code and last-note flag per (event, index).
module jingle_rom
    import snake_sound_pkg::*;
(
    input  evt_t       i_evt,
    input  logic [1:0] i_idx,
    output logic [7:0] o_freq,
    output logic       o_last
);

    always_comb begin
        o_freq = '0;
        o_last = 1'b1;
        case (i_evt)
            DIR: o_freq = NOTE_C;
            GOOD: begin
                o_last = (i_idx >= 2'd2);
                case (i_idx)
                    2'd0:    o_freq = NOTE_C;
                    2'd1:    o_freq = NOTE_E;
                    default: o_freq = NOTE_G;
                endcase
            end
            BAD: begin
                o_last = (i_idx >= 2'd2);
                case (i_idx)
                    2'd0:    o_freq = NOTE_G;
                    2'd1:    o_freq = NOTE_DS;
                    default: o_freq = NOTE_C;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sound_event_sequencer.sv
// Turns single-cycle game-event pulses into timed note jingles for the oscillator,
// with priority arbitration, one-deep per-type queuing and preemption.
module sound_event_sequencer
    import snake_sound_pkg::*;
#(
    parameter int NOTE_TICKS = 10,
    parameter int GAP_TICKS  = 2,
    parameter int TW         = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       enable,
    input  logic       dir_evt,
    input  logic       good_evt,
    input  logic       bad_evt,
    output logic [7:0] freq,
    output logic       play,
    output logic       busy,
    output logic [1:0] cur_evt
);

    seq_state_t    r_state, w_nxt_state;
    evt_t          r_cur, w_nxt_cur;
    logic [1:0]    r_idx, w_nxt_idx;
    logic [TW-1:0] r_tick, w_nxt_tick;
    logic [3:1]    r_pend, w_nxt_pend;
    logic          r_last;
    logic [7:0]    r_freq;
    logic          r_play, r_busy;

    logic [3:1]    w_req;
    evt_t          w_top;
    logic          w_start;
    logic [7:0]    w_rom_freq;
    logic          w_rom_last;

    assign w_req = enable ? (r_pend | {bad_evt, good_evt, dir_evt}) : 3'b000;
    assign w_top = top_evt(w_req);

    // Looked up on the next-state values so freq is registered on NOTE entry;
    // the last flag is kept for the note now playing.
    jingle_rom u_rom (
        .i_evt  (w_nxt_cur),
        .i_idx  (w_nxt_idx),
        .o_freq (w_rom_freq),
        .o_last (w_rom_last)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cur   = r_cur;
        w_nxt_idx   = r_idx;
        w_nxt_tick  = r_tick;
        w_start     = 1'b0;
        case (r_state)
            IDLE: w_start = (w_top != NONE);
            NOTE: begin
                if (w_top > r_cur) begin
                    w_start = 1'b1;
                end else if (r_tick == TW'(NOTE_TICKS - 1)) begin
                    w_nxt_state = GAP;
                    w_nxt_tick  = '0;
                end else begin
                    w_nxt_tick = r_tick + 1'b1;
                end
            end
            GAP: begin
                if (w_top > r_cur) begin
                    w_start = 1'b1;
                end else if (r_tick == TW'(GAP_TICKS - 1)) begin
                    if (!r_last) begin
                        w_nxt_state = NOTE;
                        w_nxt_idx   = r_idx + 1'b1;
                        w_nxt_tick  = '0;
                    end else if (w_top != NONE) begin
                        w_start = 1'b1;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_cur   = NONE;
                        w_nxt_idx   = '0;
                        w_nxt_tick  = '0;
                    end
                end else begin
                    w_nxt_tick = r_tick + 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cur   = NONE;
            end
        endcase
        // Anything not started becomes (or stays) pending; repeats coalesce.
        w_nxt_pend = w_req;
        if (w_start) begin
            w_nxt_state = NOTE;
            w_nxt_cur   = w_top;
            w_nxt_idx   = '0;
            w_nxt_tick  = '0;
            w_nxt_pend  = w_req & ~evt_mask(w_top);
        end
        if (!enable) begin
            w_nxt_state = IDLE;
            w_nxt_cur   = NONE;
            w_nxt_idx   = '0;
            w_nxt_tick  = '0;
            w_nxt_pend  = '0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
            r_cur   <= NONE;
            r_idx   <= '0;
            r_tick  <= '0;
            r_pend  <= '0;
            r_last  <= 1'b0;
            r_freq  <= '0;
            r_play  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cur   <= w_nxt_cur;
            r_idx   <= w_nxt_idx;
            r_tick  <= w_nxt_tick;
            r_pend  <= w_nxt_pend;
            r_last  <= w_rom_last;
            r_freq  <= (w_nxt_state == NOTE) ? w_rom_freq : 8'd0;
            r_play  <= (w_nxt_state == NOTE);
            r_busy  <= (w_nxt_state != IDLE);
        end
    end

    assign freq    = r_freq;
    assign play    = r_play;
    assign busy    = r_busy;
    assign cur_evt = r_cur;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Scoreboard bench: a jingle-level reference model predicts every cycle's outputs,
// a negedge monitor compares them against the sequencer.
module tb_sound_event_sequencer;

    localparam int NT = 10;
    localparam int GT = 2;
    localparam int P  = NT + GT;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       enable = 1'b0;
    logic       dir_evt = 1'b0, good_evt = 1'b0, bad_evt = 1'b0;
    logic [7:0] freq;
    logic       play, busy;
    logic [1:0] cur_evt;

    typedef struct packed {
        logic       play;
        logic [7:0] freq;
        logic       busy;
        logic [1:0] evt;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Model state: jingle being played (0 = none), cycles since its start, pending set.
    int       m_evt = 0;
    int       m_t   = 0;
    bit [3:0] m_pend = '0;

    sound_event_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .TW(8)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .enable   (enable),
        .dir_evt  (dir_evt),
        .good_evt (good_evt),
        .bad_evt  (bad_evt),
        .freq     (freq),
        .play     (play),
        .busy     (busy),
        .cur_evt  (cur_evt)
    );

    always #5 clk = ~clk;

    function automatic int note_of(input int e, input int i);
        if (e == 1) return 149;
        if (e == 2) return (i == 0) ? 149 : (i == 1) ? 118 : 100;
        if (e == 3) return (i == 0) ? 100 : (i == 1) ? 126 : 149;
        return 0;
    endfunction

    function automatic int len_of(input int e);
        return (e == 1) ? 1 : 3;
    endfunction

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m_evt  = 0;
            m_t    = 0;
            m_pend = '0;
            exp_q.delete();
        end else begin : model
            bit [3:0] req;
            int       top;
            obs_t     o;
            req = '0;
            if (enable) begin
                req    = m_pend;
                req[1] = req[1] | dir_evt;
                req[2] = req[2] | good_evt;
                req[3] = req[3] | bad_evt;
            end
            top = 0;
            for (int t = 1; t <= 3; t++) if (req[t]) top = t;
            m_pend = req;
            if (!enable) begin
                m_evt = 0;
            end else if (m_evt == 0 || top > m_evt) begin
                if (top != 0) begin
                    m_evt = top; m_t = 0; m_pend[top] = 1'b0;
                end
            end else begin
                m_t++;
                if (m_t == len_of(m_evt) * P) begin
                    if (top != 0) begin
                        m_evt = top; m_t = 0; m_pend[top] = 1'b0;
                    end else begin
                        m_evt = 0;
                    end
                end
            end
            o = '0;
            if (m_evt != 0) begin
                o.busy = 1'b1;
                o.evt  = 2'(m_evt);
                o.play = ((m_t % P) < NT);
                o.freq = o.play ? 8'(note_of(m_evt, m_t / P)) : 8'd0;
            end
            exp_q.push_back(o);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (nRst && exp_q.size() > 0) begin : monitor
            obs_t e, g;
            e = exp_q.pop_front();
            g = '{play: play, freq: freq, busy: busy, evt: cur_evt};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL cycle%0d outputs: got play=%0b freq=%0d busy=%0b evt=%0d, want play=%0b freq=%0d busy=%0b evt=%0d",
                         cyc, g.play, g.freq, g.busy, g.evt, e.play, e.freq, e.busy, e.evt);
            end
        end
    end

    task automatic check_zero(input string name);
        n_tests++;
        if (play !== 1'b0 || freq !== 8'd0 || busy !== 1'b0 || cur_evt !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: got play=%0b freq=%0d busy=%0b evt=%0d, want all zero",
                     name, play, freq, busy, cur_evt);
        end
    endtask

    task automatic step(input bit d, input bit g, input bit b, input bit en);
        @(negedge clk);
        dir_evt  = d;
        good_evt = g;
        bad_evt  = b;
        enable   = en;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 check_zero("reset_state");
        repeat (2) @(negedge clk);
        #2 nRst = 1'b1;
        idle(3);
        // GOOD jingle alone
        step(0, 1, 0, 1); idle(40);
        // DIR preempted by BAD three cycles later, no DIR replay
        step(1, 0, 0, 1); idle(2); step(0, 0, 1, 1); idle(42);
        // simultaneous pulses served BAD, GOOD, DIR
        step(1, 1, 1, 1); idle(36 * 2 + 12 + 5);
        // repeated DIR during GOOD coalesces to one replay
        step(0, 1, 0, 1); idle(5); step(1, 0, 0, 1); idle(3);
        step(1, 0, 0, 1); idle(3); step(1, 0, 0, 1); idle(50);
        // disable mid-BAD, with a BAD pulse while disabled
        step(0, 0, 1, 1); idle(15); step(0, 0, 1, 0); idle(10);
        // asynchronous reset in the middle of a DIR note
        step(1, 0, 0, 1); idle(4);
        @(negedge clk);
        #2 nRst = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk);
        #2 nRst = 1'b1;
        step(1, 0, 0, 1); idle(15);
        // randomized traffic with occasional disables
        for (int i = 0; i < 3000; i++)
            step($urandom_range(39) == 0, $urandom_range(59) == 0,
                 $urandom_range(89) == 0, $urandom_range(199) != 0);
        idle(120);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
